stepper_bank: RTL and testbench
===============================

# stepper_bank

Multi-channel stepper-motor controller that replaces the single-channel, register-bit-driven stepper driver at the top level. It takes absolute position commands over a valid/ready port and steps each channel toward its target at a programmable rate. Each channel drives one 4-wire coil group (Pmod JA-style). The processor writes commands through a memory-mapped register; this block never touches the regfile directly.

## Interface
- `CHANNELS`, 2: number of independent motor channels (1-8).
- `POS_WIDTH`, 16: width of the signed position and target values.
- `DIV_WIDTH`, 20: width of the step-rate divider counter.
- `STEP_DIV`, 250000: clocks per step (200 steps/s at 50 MHz). Legal range is 2 to 2^DIV_WIDTH-1.

Ports (direction, width, meaning):
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when high with `cmd_valid`.
- `cmd_ch`  in  $clog2(CHANNELS) (min 1)  target channel index.
- `cmd_target`  in  POS_WIDTH  signed absolute target position.
- `stop`  in  CHANNELS  per-channel stop request, level-sensitive.
- `hold_en`  in  CHANNELS  when high, an idle channel keeps its coils energised.
- `coil`  out  4*CHANNELS  channel c drives `coil[4c+3:4c]` = {A, B, A', B'}.
- `position`  out  POS_WIDTH*CHANNELS  current signed position per channel.
- `busy`  out  CHANNELS  channel is in RUN or SETTLE.
- `done`  out  CHANNELS  one-cycle pulse when a channel enters IDLE from SETTLE.

## Operation
- Each channel has its own state register, divider, position, target and phase index. All channels step concurrently.
- States:
  - IDLE to RUN when an accepted command for that channel has target ≠ position.
  - RUN to SETTLE on a tick where position == target after the update.
  - SETTLE to IDLE on the next tick.
  - Any state to IDLE immediately when `stop[c]` is high. On stop, target is set to position and no `done` pulse is issued.
- `cmd_ready` = 1 every cycle. This lets the processor re-target a moving channel.
- Command with target == position while IDLE: no state change, no `done`.
- Command in RUN or SETTLE: the target is replaced. SETTLE returns to RUN if the new target ≠ position. The divider is not reset.
- Command accepted from IDLE: the divider clears to 0.
- Tick: the divider reaches STEP_DIV-1, then wraps to 0. In IDLE the divider is held at 0.
- On a RUN tick, position moves ±1 toward target (two's-complement wrap at the POS_WIDTH limits is allowed), and the phase index moves +1 (forward) or -1 (reverse), modulo the sequence length.
- Full-step sequence, index 0-3, two-phase-on: 1100, 0110, 0011, 1001.
- Coils are driven from the phase table in RUN and SETTLE. In IDLE they are driven from the table when `hold_en[c]` is high, and are 4'b0000 when it is low.
- If `stop[c]` and a command for channel c arrive in the same cycle, stop wins and the command is dropped.

## Timing
- Reset values: all `coil` = 0, `position` = 0, target = 0, phase index = 0, `busy` = 0, `done` = 0, state IDLE, dividers 0. `cmd_ready` is 1 out of reset.
- A command accepted at edge k makes `busy` high after edge k. The first step (position and coil change) appears after edge k+STEP_DIV.
- A move of N steps raises `done` at edge k+(N+1)·STEP_DIV, with `busy` falling on the same edge.
- `stop` takes effect on the first rising edge where it is sampled high: `busy` goes low after that edge.
- Outputs are registered. Coils are glitch-free, with one coil pattern change per tick.
- A reset assertion mid-move returns every channel to its reset state asynchronously, including de-energising the coils.

## Configuration
- `STEPPER_HALFSTEP_EN`:
  - Defined: an 8-entry half-step sequence, index 0-7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. The phase index is 3 bits, and each position unit is one half step.
  - Undefined: the 4-entry full-step table only, with a 2-bit phase index.
  - Ports and handshake are identical in both builds.

## Test plan
All scenarios use STEP_DIV=4 and CHANNELS=2.
- Reset, then idle: coil=0, position=0, busy=0, done=0; with hold_en[0]=1 and `STEPPER_HALFSTEP_EN` undefined, ch0 coils = 1100.
- Command ch0 target=+3 at edge 0: ch0 coils 0110, 0011, 1001 at edges 4, 8, 12; position reaches 3 at edge 12; done[0] pulses at edge 16; busy[0] falls at edge 16.
- Command ch1 target=-2: phase index decrements (1001, then 0011); position goes -1, then -2; ch0 runs concurrently with no interaction.
- Re-target ch0 from +5 to +1 while position=3: the channel reverses, position steps 2 then 1, and then SETTLE and done fire.
- stop[0] asserted mid-move at position 2: next edge busy=0, target=2, no done; coils go to 0 with hold_en=0.
- Half-step build, target=+8: the coils walk all 8 patterns and return to 1000. Same-cycle stop and command on ch0: the command is ignored.

Source files
------------

// File: rtl/stepper_bank_if.sv
// Command port for stepper_bank: absolute position commands on valid/ready.
// Ports: cmd_valid/cmd_ready handshake, cmd_ch channel index, cmd_target signed target.
interface stepper_bank_if #(
    parameter int CHANNELS  = 2,
    parameter int POS_WIDTH = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [CH_W-1:0]             cmd_ch;
    logic signed [POS_WIDTH-1:0] cmd_target;

    modport master (
        output cmd_valid, cmd_ch, cmd_target,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_target,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_bank.sv
// Multi-channel stepper controller: steps each channel toward an absolute target.
// Ports: clock, reset (async active-low), cmd (slave command port), stop, hold_en,
// coil {A,B,A',B'} per channel, position, busy, done.
// Build option STEPPER_HALFSTEP_EN selects the 8-entry half-step table.
module stepper_bank #(
    parameter int CHANNELS  = 2,
    parameter int POS_WIDTH = 16,
    parameter int DIV_WIDTH = 20,
    parameter int STEP_DIV  = 250000
) (
    input  logic                          clock,
    input  logic                          reset,
    stepper_bank_if.slave                 cmd,
    input  logic [CHANNELS-1:0]           stop,
    input  logic [CHANNELS-1:0]           hold_en,
    output logic [4*CHANNELS-1:0]         coil,
    output logic [POS_WIDTH*CHANNELS-1:0] position,
    output logic [CHANNELS-1:0]           busy,
    output logic [CHANNELS-1:0]           done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(STEP_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

`ifdef STEPPER_HALFSTEP_EN
    localparam int PH_W = 3;

    function automatic logic [3:0] pattern(input logic [PH_W-1:0] idx);
        case (idx)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
    endfunction
`else
    localparam int PH_W = 2;

    function automatic logic [3:0] pattern(input logic [PH_W-1:0] idx);
        case (idx)
            2'd0:    pattern = 4'b1100;
            2'd1:    pattern = 4'b0110;
            2'd2:    pattern = 4'b0011;
            default: pattern = 4'b1001;
        endcase
    endfunction
`endif

    localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

    assign cmd.cmd_ready = 1'b1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]                  state, state_n;
        logic [DIV_WIDTH-1:0]        div, div_n;
        logic signed [POS_WIDTH-1:0] pos, pos_n, tgt, tgt_n;
        logic [PH_W-1:0]             ph, ph_n;
        logic                        done_n;
        logic                        hit, tick;
        logic [3:0]                  coil_q;
        logic                        busy_q, done_q;

        assign hit  = cmd.cmd_valid && (int'(cmd.cmd_ch) == c);
        assign tick = (div == DIV_LAST);

        always_comb begin
            state_n = state;
            div_n   = div;
            pos_n   = pos;
            tgt_n   = tgt;
            ph_n    = ph;
            done_n  = 1'b0;
            if (stop[c]) begin
                // stop beats a same-cycle command and freezes the target
                state_n = IDLE;
                div_n   = '0;
                tgt_n   = pos;
            end else if (state == IDLE) begin
                div_n = '0;
                if (hit && cmd.cmd_target != pos) begin
                    tgt_n   = cmd.cmd_target;
                    state_n = RUN;
                end
            end else begin
                // re-targeting a moving channel keeps the divider phase
                div_n = tick ? '0 : div + DIV_ONE;
                if (hit) tgt_n = cmd.cmd_target;
                if (state == RUN) begin
                    if (tick) begin
                        if (tgt_n > pos) begin
                            pos_n = pos + POS_ONE;
                            ph_n  = ph + PH_ONE;
                        end else if (tgt_n < pos) begin
                            pos_n = pos - POS_ONE;
                            ph_n  = ph - PH_ONE;
                        end
                        if (pos_n == tgt_n) state_n = SETTLE;
                    end
                end else begin
                    if (tgt_n != pos) begin
                        state_n = RUN;
                    end else if (tick) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                div    <= '0;
                pos    <= '0;
                tgt    <= '0;
                ph     <= '0;
                coil_q <= 4'b0000;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                state  <= state_n;
                div    <= div_n;
                pos    <= pos_n;
                tgt    <= tgt_n;
                ph     <= ph_n;
                // coils follow next-state so they change once per tick
                coil_q <= (state_n != IDLE || hold_en[c]) ? pattern(ph_n) : 4'b0000;
                busy_q <= (state_n != IDLE);
                done_q <= done_n;
            end
        end

        assign coil[4*c +: 4]                 = coil_q;
        assign position[POS_WIDTH*c +: POS_WIDTH] = pos;
        assign busy[c]                        = busy_q;
        assign done[c]                        = done_q;
    end
endmodule

// File: tb/tb_stepper_bank.sv
// Directed testbench for stepper_bank with STEP_DIV=4 and two channels.
// Exercises reset, moves, re-targeting, concurrency, stop and reset mid-move.
module tb_stepper_bank;
    localparam int CH = 2;
    localparam int PW = 16;
    localparam int SD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] stop;
    logic [CH-1:0] hold_en;
    logic [4*CH-1:0]  coil;
    logic [PW*CH-1:0] position;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;

    int vecs = 0;
    int bad  = 0;
    logic [3:0] tbl [8];
    int tlen;

    stepper_bank_if #(.CHANNELS(CH), .POS_WIDTH(PW)) cmd_if ();

    stepper_bank #(
        .CHANNELS(CH), .POS_WIDTH(PW), .DIV_WIDTH(20), .STEP_DIV(SD)
    ) dut (
        .clock(clock), .reset(reset), .cmd(cmd_if),
        .stop(stop), .hold_en(hold_en), .coil(coil),
        .position(position), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int ch, input int tgt);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_ch     = ch[0];
        cmd_if.cmd_target = 16'(tgt);
        tick();
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        stop = '0;
        hold_en = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch = '0;
        cmd_if.cmd_target = '0;
        #12;
        vecs++; if (coil !== 8'h00) begin bad++; $display("FAIL rst_coil got %h want 00", coil); end
        vecs++; if (position !== 32'h0) begin bad++; $display("FAIL rst_pos got %h want 0", position); end
        vecs++; if (busy !== 2'b00) begin bad++; $display("FAIL rst_busy got %b want 00", busy); end
        vecs++; if (done !== 2'b00) begin bad++; $display("FAIL rst_done got %b want 00", done); end
        vecs++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", cmd_if.cmd_ready); end
        reset = 1'b1;
        tick();
        tick();
        vecs++; if (coil !== 8'h00) begin bad++; $display("FAIL idle_coil got %h want 00", coil); end
        hold_en = 2'b01;
        tick();
        vecs++; if (coil[3:0] !== tbl[0]) begin bad++; $display("FAIL hold_coil0 got %b want %b", coil[3:0], tbl[0]); end
        vecs++; if (coil[7:4] !== 4'h0) begin bad++; $display("FAIL hold_coil1 got %b want 0000", coil[7:4]); end
        hold_en = 2'b00;
        tick();
        vecs++; if (coil !== 8'h00) begin bad++; $display("FAIL unhold_coil got %h want 00", coil); end
    endtask

    task automatic test_move();
        logic [15:0] ep;
        logic [3:0]  ec;
        logic        eb, ed;
        issue(0, 3);
        vecs++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL move_busy_e0 got %b want 1", busy[0]); end
        vecs++; if (coil[3:0] !== tbl[0]) begin bad++; $display("FAIL move_coil_e0 got %b want %b", coil[3:0], tbl[0]); end
        for (int e = 1; e <= 17; e++) begin
            tick();
            ep = 16'((e >= 12) ? 3 : e / 4);
            eb = (e < 16);
            ed = (e == 16);
            ec = eb ? tbl[int'(ep)] : 4'h0;
            vecs++; if (position[15:0] !== ep) begin bad++; $display("FAIL move_pos e=%0d got %0d want %0d", e, position[15:0], ep); end
            vecs++; if (busy[0] !== eb) begin bad++; $display("FAIL move_busy e=%0d got %b want %b", e, busy[0], eb); end
            vecs++; if (done[0] !== ed) begin bad++; $display("FAIL move_done e=%0d got %b want %b", e, done[0], ed); end
            vecs++; if (coil[3:0] !== ec) begin bad++; $display("FAIL move_coil e=%0d got %b want %b", e, coil[3:0], ec); end
        end
    endtask

    task automatic test_retarget();
        logic [15:0] ep;
        logic [3:0]  ec;
        logic        eb, ed;
        issue(0, 5);
        tick();
        issue(0, 1);
        for (int e = 3; e <= 13; e++) begin
            tick();
            ep = 16'((e < 4) ? 3 : (e < 8) ? 2 : 1);
            eb = (e < 12);
            ed = (e == 12);
            ec = eb ? tbl[int'(ep)] : 4'h0;
            vecs++; if (position[15:0] !== ep) begin bad++; $display("FAIL retgt_pos e=%0d got %0d want %0d", e, position[15:0], ep); end
            vecs++; if (busy[0] !== eb) begin bad++; $display("FAIL retgt_busy e=%0d got %b want %b", e, busy[0], eb); end
            vecs++; if (done[0] !== ed) begin bad++; $display("FAIL retgt_done e=%0d got %b want %b", e, done[0], ed); end
            vecs++; if (coil[3:0] !== ec) begin bad++; $display("FAIL retgt_coil e=%0d got %b want %b", e, coil[3:0], ec); end
        end
    endtask

    task automatic test_concurrent();
        int p0, p1;
        logic [3:0] ec0, ec1;
        logic eb0, ed0, eb1, ed1;
        issue(1, -2);
        vecs++; if (busy !== 2'b10) begin bad++; $display("FAIL conc_busy_e0 got %b want 10", busy); end
        issue(0, 3);
        for (int e = 2; e <= 14; e++) begin
            tick();
            p1 = (e < 4) ? 0 : (e < 8) ? -1 : -2;
            p0 = (e < 5) ? 1 : (e < 9) ? 2 : 3;
            eb1 = (e < 12);
            ed1 = (e == 12);
            eb0 = (e < 13);
            ed0 = (e == 13);
            ec1 = eb1 ? tbl[(tlen + p1) % tlen] : 4'h0;
            ec0 = eb0 ? tbl[p0] : 4'h0;
            vecs++; if (position[31:16] !== 16'(p1)) begin bad++; $display("FAIL conc_pos1 e=%0d got %h want %h", e, position[31:16], 16'(p1)); end
            vecs++; if (position[15:0] !== 16'(p0)) begin bad++; $display("FAIL conc_pos0 e=%0d got %h want %h", e, position[15:0], 16'(p0)); end
            vecs++; if (busy !== {eb1, eb0}) begin bad++; $display("FAIL conc_busy e=%0d got %b want %b", e, busy, {eb1, eb0}); end
            vecs++; if (done !== {ed1, ed0}) begin bad++; $display("FAIL conc_done e=%0d got %b want %b", e, done, {ed1, ed0}); end
            vecs++; if (coil !== {ec1, ec0}) begin bad++; $display("FAIL conc_coil e=%0d got %b want %b", e, coil, {ec1, ec0}); end
        end
    endtask

    task automatic test_stop();
        int ep;
        logic eb, ed;
        issue(0, -1);
        for (int e = 1; e <= 5; e++) tick();
        vecs++; if (position[15:0] !== 16'd2) begin bad++; $display("FAIL stop_prepos got %0d want 2", position[15:0]); end
        stop = 2'b01;
        tick();
        stop = 2'b00;
        vecs++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL stop_busy got %b want 0", busy[0]); end
        vecs++; if (done[0] !== 1'b0) begin bad++; $display("FAIL stop_done got %b want 0", done[0]); end
        vecs++; if (coil[3:0] !== 4'h0) begin bad++; $display("FAIL stop_coil got %b want 0000", coil[3:0]); end
        for (int e = 0; e < 8; e++) begin
            tick();
            vecs++; if (position[15:0] !== 16'd2 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                bad++; $display("FAIL stop_hold e=%0d pos=%0d busy=%b done=%b want 2/0/0", e, position[15:0], busy[0], done[0]);
            end
        end
        issue(0, 3);
        for (int e = 1; e <= 9; e++) begin
            tick();
            ep = (e < 4) ? 2 : 3;
            eb = (e < 8);
            ed = (e == 8);
            vecs++; if (position[15:0] !== 16'(ep)) begin bad++; $display("FAIL restart_pos e=%0d got %0d want %0d", e, position[15:0], ep); end
            vecs++; if (busy[0] !== eb || done[0] !== ed) begin bad++; $display("FAIL restart_flags e=%0d got %b%b want %b%b", e, busy[0], done[0], eb, ed); end
        end
    endtask

    task automatic test_stop_cmd();
        stop = 2'b01;
        issue(0, 6);
        stop = 2'b00;
        vecs++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL stopcmd_busy got %b want 0", busy[0]); end
        for (int e = 0; e < 6; e++) tick();
        vecs++; if (position[15:0] !== 16'd3 || busy[0] !== 1'b0) begin bad++; $display("FAIL stopcmd_hold pos=%0d busy=%b want 3/0", position[15:0], busy[0]); end
        issue(0, 3);
        vecs++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL noop_busy got %b want 0", busy[0]); end
        for (int e = 0; e < 5; e++) begin
            tick();
            vecs++; if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin bad++; $display("FAIL noop_flags e=%0d got %b%b want 00", e, busy[0], done[0]); end
        end
    endtask

    task automatic test_reset_mid();
        issue(0, 5);
        for (int e = 1; e <= 4; e++) tick();
        vecs++; if (position[15:0] !== 16'd4) begin bad++; $display("FAIL rmid_prepos got %0d want 4", position[15:0]); end
        #3;
        reset = 1'b0;
        #1;
        vecs++; if (coil !== 8'h00) begin bad++; $display("FAIL rmid_coil got %h want 00", coil); end
        vecs++; if (position !== 32'h0) begin bad++; $display("FAIL rmid_pos got %h want 0", position); end
        vecs++; if (busy !== 2'b00) begin bad++; $display("FAIL rmid_busy got %b want 00", busy); end
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_halfstep_walk();
        int p;
        logic [3:0] ec;
        logic eb, ed;
        issue(0, 8);
        for (int e = 1; e <= 36; e++) begin
            tick();
            p = (e >= 32) ? 8 : e / 4;
            eb = (e < 36);
            ed = (e == 36);
            ec = eb ? tbl[p % tlen] : 4'h0;
            vecs++; if (coil[3:0] !== ec) begin bad++; $display("FAIL walk_coil e=%0d got %b want %b", e, coil[3:0], ec); end
            vecs++; if (position[15:0] !== 16'(p)) begin bad++; $display("FAIL walk_pos e=%0d got %0d want %0d", e, position[15:0], p); end
            vecs++; if (done[0] !== ed) begin bad++; $display("FAIL walk_done e=%0d got %b want %b", e, done[0], ed); end
        end
    endtask

    initial begin
`ifdef STEPPER_HALFSTEP_EN
        tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
        tlen = 8;
`else
        tbl = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'h0, 4'h0, 4'h0, 4'h0};
        tlen = 4;
`endif
        test_reset();
        test_move();
        test_retarget();
        test_concurrent();
        test_stop();
        test_stop_cmd();
        test_reset_mid();
        test_halfstep_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule
